spi_master: RTL and testbench

- 8-bit SPI master that drives the team's SPI slave: generates sclk, ss and MOSI from a single system clock.
- Performs a full-duplex exchange: transmits a byte on MOSI while capturing a byte from MISO.
- Sits between the host-side control logic (start/busy/done handshake) and the off-block SPI pins.

---
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// 8-bit SPI master, mode 0, LSB first. Generates sclk/ss/MOSI from clk and
// exchanges one byte full-duplex per accepted start.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dataToTransmit,
  input  logic              MISO,
  output logic              sclk,
  output logic              ss,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dataRecieved
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]    CNT_MAX = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              expire;

  // MOSI is the LSB of the transmit shifter; refilling with ones makes the
  // line idle high without a separate register.
  assign MOSI         = tx_q[0];
  assign sclk         = sclk_q;
  assign ss           = ss_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dataRecieved = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '1;
      rx_q    <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    expire  = (cnt_q == CNT_MAX);

    // Half-period counter runs in every active state and wraps on expiry.
    if (state_q != IDLE) cnt_d = expire ? '0 : cnt_q + 8'd1;

    case (state_q)
      IDLE: if (start) begin
        tx_d    = dataToTransmit;
        ss_d    = 1'b0;
        busy_d  = 1'b1;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (expire) begin
        sclk_d  = 1'b1;
        state_d = HIGH;
      end
      HIGH: if (expire) begin
        sclk_d = 1'b0;
        rx_d   = {MISO, rx_q[DATA_W-1:1]};
        if (bit_q == BIT_MAX) begin
          state_d = HOLD;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = {1'b1, tx_q[DATA_W-1:1]};
          state_d = LOW;
        end
      end
      LOW: if (expire) begin
        sclk_d  = 1'b1;
        state_d = HIGH;
      end
      HOLD: if (expire) begin
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        data_d  = rx_q;
        tx_d    = '1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1), a byte-level
// slave model, and a scoreboard of expected transfers popped on each done.
module tb_spi_master;
  localparam int N = 2;

  typedef struct {
    int         acc;
    logic [7:0] tx;
    logic [7:0] rx;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]      start = '0;
  logic [N-1:0][7:0] din = '0;
  logic [N-1:0]      miso, sclk, ss, mosi, busy, done;
  logic [N-1:0][7:0] drx;
  logic [N-1:0]      loopb = '1;
  logic [N-1:0]      slv_miso = '0;
  logic [N-1:0][7:0] slv_byte = '0;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  txn_t exp_q [N][$];

  int         nrise [N];
  logic [7:0] slv_rx [N];
  logic [N-1:0] p_sclk = '0, p_ss = '1, p_done = '0;
  txn_t mt;

  assign miso = (loopb & mosi) | (~loopb & slv_miso);

  spi_master #(.CLK_DIV(4), .DATA_W(8)) u_div4 (
    .clk(clk), .reset(reset), .start(start[0]), .dataToTransmit(din[0]),
    .MISO(miso[0]), .sclk(sclk[0]), .ss(ss[0]), .MOSI(mosi[0]),
    .busy(busy[0]), .done(done[0]), .dataRecieved(drx[0]));

  spi_master #(.CLK_DIV(1), .DATA_W(8)) u_div1 (
    .clk(clk), .reset(reset), .start(start[1]), .dataToTransmit(din[1]),
    .MISO(miso[1]), .sclk(sclk[1]), .ss(ss[1]), .MOSI(mosi[1]),
    .busy(busy[1]), .done(done[1]), .dataRecieved(drx[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model + scoreboard monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        nrise[i] <= 0;
      end else begin
        if (sclk[i] && !p_sclk[i]) begin
          check("ss_low_on_sclk_rise", {31'd0, ss[i]}, 32'd0);
          slv_rx[i] <= {mosi[i], slv_rx[i][7:1]};
          if (nrise[i] < 8) slv_miso[i] <= slv_byte[i][nrise[i][2:0]];
          nrise[i] <= nrise[i] + 1;
        end
        if (done[i]) begin
          check("done_single_cycle", {31'd0, p_done[i]}, 32'd0);
          if (exp_q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: inst %0d got done with no transfer pending (cycle %0d)", i, cyc);
          end else begin
            mt = exp_q[i].pop_front();
            check("done_latency", cyc, mt.acc + 17 * div_of(i));
            check("master_rx", {24'd0, drx[i]}, {24'd0, mt.rx});
            check("slave_rx", {24'd0, slv_rx[i]}, {24'd0, mt.tx});
            check("sclk_rises", nrise[i], 8);
            check("ss_high_at_done", {31'd0, ss[i]}, 32'd1);
            check("busy_low_at_done", {31'd0, busy[i]}, 32'd0);
          end
        end
        if (ss[i] && !p_ss[i]) nrise[i] <= 0;
      end
    end
    p_sclk <= sclk;
    p_ss   <= ss;
    p_done <= done;
  end

  task automatic xfer(int i, logic [7:0] tx, logic lb, logic [7:0] sb);
    @(negedge clk);
    loopb[i]    = lb;
    slv_byte[i] = sb;
    din[i]      = tx;
    start[i]    = 1'b1;
    @(posedge clk);
    #1;
    check("ss_fall_at_accept", {31'd0, ss[i]}, 32'd0);
    check("busy_at_accept", {31'd0, busy[i]}, 32'd1);
    exp_q[i].push_back('{cyc, tx, lb ? tx : sb});
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_drain(int i);
    for (int k = 0; k < 3000 && exp_q[i].size() != 0; k++) @(negedge clk);
    check("drain_timeout", exp_q[i].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        check("idle_outputs", {26'd0, sclk[i], ss[i], mosi[i], busy[i], done[i], 1'b0} | {24'd0, drx[i]} << 8,
              32'b0_0000_0000_0000_0000_0000_0000_011000);
    end

    // Loopback and slave-byte exchanges at CLK_DIV=4
    xfer(0, 8'hA5, 1'b1, 8'h00);
    wait_drain(0);
    xfer(0, 8'h81, 1'b0, 8'h3C);
    wait_drain(0);

    // start held high; data changes mid-transfer; second accepted in done cycle
    @(negedge clk);
    loopb[0] = 1'b1;
    din[0]   = 8'h01;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q[0].push_back('{acc, 8'h01, 8'h01});
    exp_q[0].push_back('{acc + 69, 8'hFE, 8'hFE});
    repeat (10) @(negedge clk);
    din[0] = 8'hFE;
    while (cyc < acc + 68) @(negedge clk);
    check("ss_gap_high", {31'd0, ss[0]}, 32'd1);
    @(negedge clk);
    check("ss_gap_one_cycle", {31'd0, ss[0]}, 32'd0);
    start[0] = 1'b0;
    wait_drain(0);

    // Reset after the 4th sclk rise aborts the transfer
    xfer(0, 8'hC3, 1'b1, 8'h00);
    for (int k = 0; k < 200 && nrise[0] < 4; k++) @(negedge clk);
    check("reached_4_rises", nrise[0], 4);
    reset = 1'b1;
    @(negedge clk);
    exp_q[0].delete();
    check("abort_ss", {31'd0, ss[0]}, 32'd1);
    check("abort_sclk", {31'd0, sclk[0]}, 32'd0);
    check("abort_busy", {31'd0, busy[0]}, 32'd0);
    check("abort_done", {31'd0, done[0]}, 32'd0);
    check("abort_data", {24'd0, drx[0]}, 32'd0);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    xfer(0, 8'h6E, 1'b0, 8'hB7);
    wait_drain(0);

    // CLK_DIV=1 with ignored start pulses during busy
    xfer(1, 8'h5A, 1'b1, 8'h00);
    repeat (3) begin
      @(negedge clk);
      din[1]   = 8'hFF;
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
    end
    wait_drain(1);
    repeat (30) @(negedge clk);
    check("div1_result_held", {24'd0, drx[1]}, 32'h5A);
    check("div1_idle_busy", {31'd0, busy[1]}, 32'd0);

    // Randomized transfers on both instances
    for (int n = 0; n < 24; n++) begin
      int   i;
      logic [7:0] tx, sb;
      logic lb;
      i  = int'($urandom_range(0, 1));
      tx = 8'($urandom);
      sb = 8'($urandom);
      lb = 1'($urandom_range(0, 1));
      xfer(i, tx, lb, sb);
      wait_drain(i);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_drain(0);
    wait_drain(1);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
